// File: rtl/prn_line_feeder.sv
// Print-head line feeder: ping-pong line buffer and SP register file that feed
// the serializer with Prn_Data/SPdata words on its request strobes.
module prn_line_feeder #(
    parameter int BANK_AW = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  PrintHead_Type,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        sp_wr_en,
    input  logic [3:0]  sp_wr_addr,
    input  logic [15:0] sp_wr_data,
    input  logic        fire_trig,
    output logic        SCK_req,
    input  logic        data_req,
    output logic [15:0] Prn_Data,
    input  logic        SPdata_start,
    input  logic        SPdata_req,
    output logic [15:0] SPdata,
    input  logic        data_end,
    input  logic        err_clr,
    output logic        overflow,
    output logic        underrun,
    output logic        over_read
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = BANK_AW + 1;
    localparam int DEPTH  = 2 ** (BANK_AW + 1);
    localparam logic [PTR_W-1:0] LW_SHORT = PTR_W'(180);
    localparam logic [PTR_W-1:0] LW_LONG  = PTR_W'(200);

    typedef enum logic [2:0] {
        R_IDLE,
        R_PREP,
        R_REQ,
        R_RUN,
        R_DONE
    } rstate_t;

    rstate_t            state_q;

    logic               type_short;
    logic               type_long;
    logic [PTR_W-1:0]   line_words_q;
    logic [PTR_W-1:0]   line_words_d;
    logic [4:0]         sp_words_q;
    logic [4:0]         sp_words_d;

    logic [1:0]         full_q;
    logic [1:0]         full_d;
    logic               wr_bank_q;
    logic               wr_bank_d;
    logic [BANK_AW-1:0] wr_ptr_q;
    logic [BANK_AW-1:0] wr_ptr_d;
    logic               wr_fire;
    logic               wr_last;

    logic               rd_bank_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_next;
    logic               serve;
    logic               rd_in_range;
    logic               rd_beyond;
    logic               rd_en;
    logic [BANK_AW:0]   rd_addr;
    logic [DATA_W-1:0]  ram_q;
    logic               prn_zero_q;
    logic               sck_q;

    logic               overflow_q;
    logic               underrun_q;
    logic               over_read_q;
    logic               overflow_set;
    logic               underrun_set;
    logic               over_read_set;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  sp_reg [16];
    logic [3:0]         sp_ptr_q;
    logic [3:0]         sp_ptr_d;
    logic [4:0]         sp_inc;
    logic [DATA_W-1:0]  spdata_q;
    logic [DATA_W-1:0]  spdata_d;

    // Head-type decode; unknown types leave both lengths unchanged.
    always_comb begin
        type_short   = (PrintHead_Type >= 8'h02) && (PrintHead_Type <= 8'h05);
        type_long    = (PrintHead_Type == 8'h01) || (PrintHead_Type == 8'h06);
        line_words_d = line_words_q;
        sp_words_d   = sp_words_q;
        if (type_short) begin
            sp_words_d = 5'd16;
        end else if (type_long) begin
            sp_words_d = 5'd8;
        end
        if (state_q == R_IDLE) begin
            if (type_short) begin
                line_words_d = LW_SHORT;
            end else if (type_long) begin
                line_words_d = LW_LONG;
            end
        end
    end

    assign wr_ready = ~full_q[wr_bank_q];
    assign wr_fire  = wr_en & wr_ready;
    assign wr_last  = ({1'b0, wr_ptr_q} >= (line_words_q - PTR_W'(1)));

    // Writer full-mark and reader release touch different banks, so both apply.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        if (wr_fire) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + BANK_AW'(1);
            end
        end
        if (state_q == R_DONE) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            line_words_q <= LW_SHORT;
            sp_words_q   <= 5'd16;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            line_words_q <= line_words_d;
            sp_words_q   <= sp_words_d;
        end
    end

    // Look-ahead address: the word after rd_ptr is fetched on the request edge.
    assign rd_next     = rd_ptr_q + PTR_W'(1);
    assign serve       = (state_q == R_RUN) & data_req;
    assign rd_in_range = (rd_next < line_words_q);
    assign rd_beyond   = (rd_next > line_words_q);
    assign rd_en       = (state_q == R_PREP) | (serve & rd_in_range);
    assign rd_addr     = {rd_bank_q, (state_q == R_PREP) ? {BANK_AW{1'b0}} : rd_next[BANK_AW-1:0]};

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_q, wr_ptr_q}] <= wr_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= R_IDLE;
            sck_q      <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            prn_zero_q <= 1'b1;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (fire_trig && full_q[rd_bank_q]) begin
                        state_q <= R_PREP;
                    end
                end
                R_PREP: begin
                    rd_ptr_q   <= '0;
                    prn_zero_q <= 1'b0;
                    sck_q      <= 1'b1;
                    state_q    <= R_REQ;
                end
                R_REQ: begin
                    if (!data_end) begin
                        sck_q   <= 1'b0;
                        state_q <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (data_req) begin
                        prn_zero_q <= ~rd_in_range;
                        if (rd_ptr_q < line_words_q) begin
                            rd_ptr_q <= rd_next;
                        end
                    end
                    if (data_end) begin
                        state_q <= R_DONE;
                    end
                end
                R_DONE: begin
                    rd_bank_q <= ~rd_bank_q;
                    state_q   <= R_IDLE;
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign overflow_set  = wr_en & ~wr_ready;
    assign underrun_set  = (state_q == R_IDLE) & fire_trig & ~full_q[rd_bank_q];
    assign over_read_set = serve & rd_beyond;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            over_read_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_set  | (overflow_q  & ~err_clr);
            underrun_q  <= underrun_set  | (underrun_q  & ~err_clr);
            over_read_q <= over_read_set | (over_read_q & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (sp_wr_en) begin
            sp_reg[sp_wr_addr] <= sp_wr_data;
        end
    end

    assign sp_inc = {1'b0, sp_ptr_q} + 5'd1;

    always_comb begin
        sp_ptr_d = sp_ptr_q;
        spdata_d = spdata_q;
        if (SPdata_start) begin
            sp_ptr_d = '0;
            spdata_d = sp_reg[0];
        end else if (SPdata_req) begin
            sp_ptr_d = (sp_inc >= sp_words_q) ? 4'd0 : sp_inc[3:0];
            spdata_d = sp_reg[sp_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_ptr_q <= '0;
            spdata_q <= '0;
        end else begin
            sp_ptr_q <= sp_ptr_d;
            spdata_q <= spdata_d;
        end
    end

    assign SCK_req   = sck_q;
    assign Prn_Data  = prn_zero_q ? '0 : ram_q;
    assign SPdata    = spdata_q;
    assign overflow  = overflow_q;
    assign underrun  = underrun_q;
    assign over_read = over_read_q;

endmodule

// File: doc/prn_line_feeder.md
# prn_line_feeder

Upstream stage of the print-head serializer. Buffers one nozzle-line of print data per fire in a two-bank ping-pong RAM and holds a 16-entry SP (waveform-select) register file. On a fire trigger it starts one serializer cycle by pulsing `SCK_req`, then delivers `Prn_Data` and `SPdata` words on the serializer's `data_req`/`SPdata_req` strobes. Each bank is released when the serializer returns to idle.

## Interface
Parameters:
- `BANK_AW`, default 8: bank address width; each bank holds 256 × 16 bit.

Ports:
- `clk`  in  1: single clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `PrintHead_Type`  in  8: selects line and SP lengths.
- `wr_en`  in  1: host write strobe for line data.
- `wr_data`  in  16: host line-data word.
- `wr_ready`  out  1: write bank can accept a word.
- `sp_wr_en`  in  1: SP register write strobe.
- `sp_wr_addr`  in  4: SP register index.
- `sp_wr_data`  in  16: SP register value.
- `fire_trig`  in  1: one-cycle fire pulse.
- `SCK_req`  out  1: serializer start request.
- `data_req`  in  1: serializer request for the next `Prn_Data` word.
- `Prn_Data`  out  16: print-data word to the serializer.
- `SPdata_start`  in  1: serializer starts the SP phase.
- `SPdata_req`  in  1: serializer request for the next SP word.
- `SPdata`  out  16: SP word to the serializer.
- `data_end`  in  1: serializer idle flag (high = idle).
- `err_clr`  in  1: clears the sticky error flags.
- `overflow`  out  1: sticky; a write was attempted while `wr_ready` was low.
- `underrun`  out  1: sticky; a fire arrived with no full bank.
- `over_read`  out  1: sticky; `data_req` count exceeded `line_words`.

## Operation
- `line_words` = 180 for types 02–05; 200 for types 01/06; any other type holds the previous value. Reset value is 180. The register updates only while the read FSM is in R_IDLE.
- `sp_words` = 16 for types 02–05; 8 for types 01/06; reset value is 16.
- Write side:
  - `wr_ready` = the current write bank is not full.
  - `wr_en & wr_ready` writes the word to `wr_bank[wr_ptr]` and increments `wr_ptr`.
  - When the write that reaches `wr_ptr == line_words-1` occurs, the bank is marked full, `wr_ptr` goes to 0 and `wr_bank` toggles.
  - `wr_en` while `wr_ready` is low drops the word and sets `overflow`.
- Read FSM:
  - R_IDLE: on `fire_trig` with `rd_bank` full, go to R_PREP. If `rd_bank` is not full, set `underrun` and stay. `fire_trig` outside R_IDLE is ignored with no flag.
  - R_PREP: `rd_ptr` ← 0; issue the RAM read of word 0. Go to R_REQ.
  - R_REQ: `Prn_Data` ← word 0 and `SCK_req` = 1. `SCK_req` stays high until `data_end` is sampled low, then go to R_RUN.
  - R_RUN: serve requests; on `data_end` high, go to R_DONE.
  - R_DONE: mark `rd_bank` empty, toggle `rd_bank`, go to R_IDLE.
- `data_req` in R_RUN:
  - `Prn_Data` ← word `rd_ptr+1` and `rd_ptr` increments.
  - Once `rd_ptr+1 == line_words`, further requests load `Prn_Data` = 0 and set `over_read`.
- SP path, active in any state:
  - `SPdata_start` sets `sp_ptr` ← 0 and `SPdata` ← `sp_reg[0]`.
  - `SPdata_req` increments `sp_ptr` modulo `sp_words` and sets `SPdata` ← `sp_reg[sp_ptr+1]`.
  - `sp_wr_en` writes `sp_reg[sp_wr_addr]`; it is not blocked during a fire.
- Banks are never shared: a bank being read is full, so `wr_ready` stays low for it.
- Simultaneous events:
  - Full-mark by the writer and release by R_DONE on different banks in the same cycle both take effect.
  - `err_clr` together with a new error event: the set wins.
- Reset mid-operation:
  - All state returns to reset; banks are empty and pointers are 0.
  - RAM contents are don't-care.

## Timing
- Reset values: `wr_ready` = 1; `SCK_req`, `Prn_Data`, `SPdata`, `overflow`, `underrun` and `over_read` = 0.
- `fire_trig` → `SCK_req` high: 2 cycles (R_PREP, then R_REQ). Word 0 is valid on `Prn_Data` in the same cycle `SCK_req` rises.
- `Prn_Data` / `SPdata` change on the clock edge after a request is sampled (1-cycle latency). A request on every cycle is supported, using a synchronous-read RAM with a look-ahead address.
- Bank release: 1 cycle after `data_end` is sampled high in R_RUN; `wr_ready` can rise the following cycle.
- Sticky flags set on the cycle after the offending event.

## Test plan
1. Type 02:
   - Stimulus: write 180 words 0x0000–0x00B3, then fire.
   - Response: `SCK_req` 2 cycles after the fire; 90 `data_req` return 0x0001…0x005A in order; bank released after `data_end`; `wr_ready` stays 1 (second bank empty) throughout.
2. Type 06:
   - Stimulus: fill both banks (200 words each), then keep writing.
   - Response: `wr_ready` = 0 after word 400; the 401st write sets `overflow`. After one fire completes, `wr_ready` = 1 and the next write lands in bank 0 at address 0.
3. Fire with both banks empty → `underrun` = 1 and no `SCK_req`. Then `err_clr` → `underrun` = 0.
4. SP path:
   - Stimulus: load `sp_reg[i]` = 0xA000+i; type 01; `SPdata_start`, then 10 `SPdata_req`.
   - Response: `SPdata` sequence 0xA000…0xA007, 0xA000, 0xA001, 0xA002 (wraps at 8).
5. Type 02 with 181 `data_req` → the 181st returns 0x0000 and `over_read` = 1.
6. Assert `rstn` low during R_RUN → all outputs go to reset values immediately; a following fill plus fire behaves exactly as in scenario 1.
